// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-arbiter definitions: datapath widths, x0 index, state encodings and the
// default starvation bound.
package wb_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned REG_IDX_WIDTH = 5;
    localparam int unsigned WB_STARVE_MAX = 4;

    localparam logic [REG_IDX_WIDTH-1:0] REG_X0 = '0;

    typedef enum logic {
        ARB_ALU = 1'b0,
        ARB_LSU = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_bypass.sv
// Forwards the registered regfile write to both decode read ports.
// The forward path exists only when WB_BYPASS_EN is defined; otherwise raw data passes through.
module wb_bypass
    import wb_arbiter_pkg::*;
(
    input  logic                     rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] rd_idx_i,
    input  logic [XLEN-1:0]          rd_wdata_i,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
    input  logic [XLEN-1:0]          rs1_rdata_i,
    input  logic [XLEN-1:0]          rs2_rdata_i,
    output logic [XLEN-1:0]          rs1_rdata_o,
    output logic [XLEN-1:0]          rs2_rdata_o
);

`ifdef WB_BYPASS_EN
    logic rs1_hit;
    logic rs2_hit;

    // rd_en is already low for x0 writes; the x0 term keeps x0 reads hard-wired regardless.
    assign rs1_hit = rd_en_i && (rd_idx_i == rs1_idx_i) && (rs1_idx_i != REG_X0);
    assign rs2_hit = rd_en_i && (rd_idx_i == rs2_idx_i) && (rs2_idx_i != REG_X0);

    assign rs1_rdata_o = rs1_hit ? rd_wdata_i : rs1_rdata_i;
    assign rs2_rdata_o = rs2_hit ? rd_wdata_i : rs2_rdata_i;
`else
    logic unused_bypass;

    assign unused_bypass = ^{rd_en_i, rd_idx_i, rd_wdata_i, rs1_idx_i, rs2_idx_i};
    assign rs1_rdata_o   = rs1_rdata_i;
    assign rs2_rdata_o   = rs2_rdata_i;
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates ALU and LSU/MDU writebacks onto the single regfile write port with LSU
// anti-starvation; read-port forwarding is enabled by defining WB_BYPASS_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [REG_IDX_WIDTH-1:0] alu_rd_idx_i,
    input  logic [XLEN-1:0]          alu_wdata_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [REG_IDX_WIDTH-1:0] lsu_rd_idx_i,
    input  logic [XLEN-1:0]          lsu_wdata_i,
    output logic                     rd_en_o,
    output logic [REG_IDX_WIDTH-1:0] rd_idx_o,
    output logic [XLEN-1:0]          rd_wdata_o,
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
    input  logic [XLEN-1:0]          rs1_rdata_i,
    input  logic [XLEN-1:0]          rs2_rdata_i,
    output logic [XLEN-1:0]          rs1_rdata_o,
    output logic [XLEN-1:0]          rs2_rdata_o
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    arb_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic alu_xfer;
    logic lsu_xfer;

    logic                     rd_en_d;
    logic [REG_IDX_WIDTH-1:0] rd_idx_d;
    logic [XLEN-1:0]          rd_wdata_d;

    always_comb begin
        alu_ready_o = 1'b0;
        lsu_ready_o = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ARB_ALU: begin
                    alu_ready_o = alu_valid_i;
                    lsu_ready_o = lsu_valid_i & ~alu_valid_i;
                end
                ARB_LSU: begin
                    lsu_ready_o = lsu_valid_i;
                    alu_ready_o = alu_valid_i & ~lsu_valid_i;
                end
                default: ;
            endcase
        end
    end

    assign alu_xfer = alu_valid_i & alu_ready_o;
    assign lsu_xfer = lsu_valid_i & lsu_ready_o;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;

        if (!lsu_valid_i || lsu_xfer) begin
            cnt_d = '0;
        end else if (state_q == ARB_ALU && cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Flip on the edge that loads the bound, so the LSU wins on contended cycle STARVE_MAX+1.
        unique case (state_q)
            ARB_ALU: if (cnt_d == CntMax) state_d = ARB_LSU;
            ARB_LSU: if (lsu_xfer || !lsu_valid_i) state_d = ARB_ALU;
            default: state_d = ARB_ALU;
        endcase
    end

    always_comb begin
        rd_en_d    = 1'b0;
        rd_idx_d   = rd_idx_o;
        rd_wdata_d = rd_wdata_o;
        if (alu_xfer) begin
            rd_en_d    = (alu_rd_idx_i != REG_X0);
            rd_idx_d   = alu_rd_idx_i;
            rd_wdata_d = alu_wdata_i;
        end else if (lsu_xfer) begin
            rd_en_d    = (lsu_rd_idx_i != REG_X0);
            rd_idx_d   = lsu_rd_idx_i;
            rd_wdata_d = lsu_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_ALU;
            cnt_q      <= '0;
            rd_en_o    <= 1'b0;
            rd_idx_o   <= '0;
            rd_wdata_o <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_en_o    <= rd_en_d;
            rd_idx_o   <= rd_idx_d;
            rd_wdata_o <= rd_wdata_d;
        end
    end

    wb_bypass u_wb_bypass (
        .rd_en_i     (rd_en_o),
        .rd_idx_i    (rd_idx_o),
        .rd_wdata_i  (rd_wdata_o),
        .rs1_idx_i   (rs1_idx_i),
        .rs2_idx_i   (rs2_idx_i),
        .rs1_rdata_i (rs1_rdata_i),
        .rs2_rdata_i (rs2_rdata_i),
        .rs1_rdata_o (rs1_rdata_o),
        .rs2_rdata_o (rs2_rdata_o)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: per-cycle expected readies, scoreboard of registered writes.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_idx_i;
    logic [31:0] alu_wdata_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_idx_i;
    logic [31:0] lsu_wdata_i;
    logic        rd_en_o;
    logic [4:0]  rd_idx_o;
    logic [31:0] rd_wdata_o;
    logic [4:0]  rs1_idx_i;
    logic [4:0]  rs2_idx_i;
    logic [31:0] rs1_rdata_i;
    logic [31:0] rs2_rdata_i;
    logic [31:0] rs1_rdata_o;
    logic [31:0] rs2_rdata_o;

    typedef struct {
        logic        en;
        logic [4:0]  idx;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  last_idx;
    logic [31:0] last_data;
    bit          last_chk;
    int          checks;
    int          failures;

    always #5 clk = ~clk;

    wb_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rd_idx_i (alu_rd_idx_i),
        .alu_wdata_i  (alu_wdata_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_idx_i (lsu_rd_idx_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .rd_en_o      (rd_en_o),
        .rd_idx_o     (rd_idx_o),
        .rd_wdata_o   (rd_wdata_o),
        .rs1_idx_i    (rs1_idx_i),
        .rs2_idx_i    (rs2_idx_i),
        .rs1_rdata_i  (rs1_rdata_i),
        .rs2_rdata_i  (rs2_rdata_i),
        .rs1_rdata_o  (rs1_rdata_o),
        .rs2_rdata_o  (rs2_rdata_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Model one accepted write: x0 is accepted but does not enable the write port.
    task automatic model_write(input logic [4:0] idx, input logic [31:0] data, output exp_t e);
        if (idx != 5'd0) begin
            e.en = 1'b1; e.idx = idx; e.data = data; e.chk = 1'b1;
            last_idx = idx; last_data = data; last_chk = 1'b1;
        end else begin
            e.en = 1'b0; e.idx = '0; e.data = '0; e.chk = 1'b0;
            last_chk = 1'b0;
        end
    endtask

    task automatic step(input bit r,
                        input bit av, input logic [4:0] ai, input logic [31:0] ad,
                        input bit lv, input logic [4:0] li, input logic [31:0] ld,
                        input bit ear, input bit elr, input string tag);
        exp_t e;
        rst          = r;
        alu_valid_i  = av;
        alu_rd_idx_i = ai;
        alu_wdata_i  = ad;
        lsu_valid_i  = lv;
        lsu_rd_idx_i = li;
        lsu_wdata_i  = ld;
        @(negedge clk);
        check({tag, ".alu_ready"}, 32'(alu_ready_o), 32'(ear));
        check({tag, ".lsu_ready"}, 32'(lsu_ready_o), 32'(elr));
        if (r) begin
            e.en = 1'b0; e.idx = '0; e.data = '0; e.chk = 1'b1;
            last_idx = '0; last_data = '0; last_chk = 1'b1;
        end else if (ear) begin
            model_write(ai, ad, e);
        end else if (elr) begin
            model_write(li, ld, e);
        end else begin
            e.en = 1'b0; e.idx = last_idx; e.data = last_data; e.chk = last_chk;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".rd_en"}, 32'(rd_en_o), 32'(e.en));
        if (e.chk) begin
            check({tag, ".rd_idx"}, 32'(rd_idx_o), 32'(e.idx));
            check({tag, ".rd_wdata"}, rd_wdata_o, e.data);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        last_idx = '0; last_data = '0; last_chk = 1'b0;
        rst = 1'b1;
        alu_valid_i = 1'b0; alu_rd_idx_i = '0; alu_wdata_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_idx_i = '0; lsu_wdata_i = '0;
        rs1_idx_i = '0; rs2_idx_i = '0; rs1_rdata_i = '0; rs2_rdata_i = '0;
        @(posedge clk);
        #1;

        // Reset: readies held low even with requests present.
        step(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0, "reset");

        // Single ALU write, then idle holds index/data with enable low.
        step(0, 1, 5'd5, 32'h1234_5678, 0, 5'd0, 32'h0, 1, 0, "alu_single");
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, "idle_hold");

        // Contention: ALU first, LSU once ALU drops.
        step(0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB, 1, 0, "cont_alu");
        step(0, 0, 5'd0, 32'h0, 1, 5'd4, 32'hB, 0, 1, "cont_lsu");

        // Starvation: LSU forced in on the 5th contended cycle, ALU priority after.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5'(10 + i), 32'(32'h100 + i), 1, 5'd7, 32'hDEAD, 1, 0, "starve_alu");
        end
        step(0, 1, 5'd14, 32'h104, 1, 5'd7, 32'hDEAD, 0, 1, "starve_lsu");
        step(0, 1, 5'd14, 32'h104, 0, 5'd0, 32'h0, 1, 0, "starve_after");
        step(0, 1, 5'd15, 32'h105, 1, 5'd8, 32'hBEEF, 1, 0, "alu_prio_back");
        step(0, 0, 5'd0, 32'h0, 1, 5'd8, 32'hBEEF, 0, 1, "lsu_drain");

        // x0 write accepted without enabling the port.
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0, 1, "x0_write");

        // Back-to-back writes to one index; the later value lands last.
        step(0, 1, 5'd9, 32'h11, 0, 5'd0, 32'h0, 1, 0, "b2b_first");
        step(0, 1, 5'd9, 32'h55, 0, 5'd0, 32'h0, 1, 0, "b2b_second");

        // x9=0x55 now on the write port.
        rs1_idx_i = 5'd9; rs1_rdata_i = 32'h0;
        rs2_idx_i = 5'd8; rs2_rdata_i = 32'h77;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_rs1", rs1_rdata_o, 32'h55);
`else
        check("bypass_rs1", rs1_rdata_o, 32'h0);
`endif
        check("bypass_rs2_miss", rs2_rdata_o, 32'h77);
        rs1_idx_i = '0; rs2_idx_i = '0; rs2_rdata_i = '0;

        // Reset mid-contention with counter at 3: counter restarts, LSU request survives.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'(20 + i), 32'(32'h200 + i), 1, 5'd2, 32'h22, 1, 0, "pre_rst_alu");
        end
        step(1, 1, 5'd23, 32'h203, 1, 5'd2, 32'h22, 0, 0, "rst_contention");
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5'(24 + i), 32'(32'h300 + i), 1, 5'd2, 32'h22, 1, 0, "post_rst_alu");
        end
        step(0, 1, 5'd28, 32'h304, 1, 5'd2, 32'h22, 0, 1, "post_rst_lsu");
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
